// File: rtl/sdram_arb_pkg.sv
// Shared types for the SDRAM arbiter: FSM states, grant index and default ack timeout.
package sdram_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT
   } state_t;

   typedef enum logic [1:0] {
      GNT_IO,
      GNT_C64,
      GNT_REU
   } gnt_t;

   localparam int TIMEOUT_DEF = 15;

endpackage

// File: rtl/sdram_arb_pick.sv
// Grant picker: io always wins; c64/reu round-robin (last served loses a tie) under REU_ARB_PORT_EN.
// Latency: purely combinational, no state.
// Backpressure: none; the caller masks requests it does not want considered.
module sdram_arb_pick
   import sdram_arb_pkg::*;
(
   input  logic io_req,
   input  logic c64_req,
`ifdef REU_ARB_PORT_EN
   input  logic reu_req,
   input  logic last_reu,
`endif
   output logic any_req,
   output gnt_t gnt
);

   always_comb begin
      gnt     = GNT_IO;
      any_req = io_req | c64_req;
`ifdef REU_ARB_PORT_EN
      any_req = any_req | reu_req;
      if (io_req)
         gnt = GNT_IO;
      else if (c64_req && reu_req)
         gnt = last_reu ? GNT_C64 : GNT_REU;
      else if (c64_req)
         gnt = GNT_C64;
      else if (reu_req)
         gnt = GNT_REU;
`else
      if (!io_req && c64_req)
         gnt = GNT_C64;
`endif
   end

endmodule

// File: rtl/sdram_arbiter.sv
// SDRAM arbiter: io > {c64, reu round-robin} onto one SDRAM controller port; reu port exists under REU_ARB_PORT_EN.
// Latency: request seen in IDLE -> sd_req next cycle; requester ack one cycle after sd_ack (sd latency + 2 per transaction).
// Backpressure: requesters hold req until ack; no sd_ack within TIMEOUT WAIT cycles aborts silently and sets sticky arb_err.
module sdram_arbiter
   import sdram_arb_pkg::*;
#(
   parameter int ADDR_W  = 25,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic              clk_sys,
   input  logic              reset_n,
   input  logic              io_req,
   input  logic              io_we,
   input  logic [ADDR_W-1:0] io_addr,
   input  logic [7:0]        io_din,
   output logic              io_ack,
   input  logic              c64_req,
   input  logic              c64_we,
   input  logic [ADDR_W-1:0] c64_addr,
   input  logic [7:0]        c64_din,
   output logic              c64_ack,
   output logic [7:0]        c64_dout,
`ifdef REU_ARB_PORT_EN
   input  logic              reu_req,
   input  logic              reu_we,
   input  logic [ADDR_W-1:0] reu_addr,
   input  logic [7:0]        reu_din,
   output logic              reu_ack,
   output logic [7:0]        reu_dout,
`endif
   output logic              sd_req,
   output logic              sd_we,
   output logic [ADDR_W-1:0] sd_addr,
   output logic [7:0]        sd_din,
   input  logic [7:0]        sd_dout,
   input  logic              sd_ack,
   output logic              arb_err
);

   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [7:0]        din;
   } xact_t;

   localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

   state_t     state_q, state_nxt;
   gnt_t       pick_gnt, gnt_q;
   xact_t      win_x, cur_x;
   logic       pick_vld, start, done, tmo;
   logic [7:0] wait_cnt_q;
`ifdef REU_ARB_PORT_EN
   logic       last_reu_q;
`endif

   // The port acked this cycle still shows its old req; keep it out of the pick.
   sdram_arb_pick u_pick (
      .io_req   (io_req & ~io_ack),
      .c64_req  (c64_req & ~c64_ack),
`ifdef REU_ARB_PORT_EN
      .reu_req  (reu_req & ~reu_ack),
      .last_reu (last_reu_q),
`endif
      .any_req  (pick_vld),
      .gnt      (pick_gnt)
   );

   always_comb begin
      win_x = '{we: c64_we, addr: c64_addr, din: c64_din};
      case (pick_gnt)
         GNT_IO:  win_x = '{we: io_we, addr: io_addr, din: io_din};
`ifdef REU_ARB_PORT_EN
         GNT_REU: win_x = '{we: reu_we, addr: reu_addr, din: reu_din};
`endif
         default: ;
      endcase
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n)
         state_q <= IDLE;
      else
         state_q <= state_nxt;
   end

   always_comb begin
      state_nxt = state_q;
      start     = 1'b0;
      done      = 1'b0;
      tmo       = 1'b0;
      case (state_q)
         IDLE: begin
            if (pick_vld) begin
               start     = 1'b1;
               state_nxt = ISSUE;
            end
         end
         ISSUE: state_nxt = WAIT;
         WAIT: begin
            if (sd_ack) begin
               done      = 1'b1;
               state_nxt = IDLE;
            end else if (wait_cnt_q == WAIT_LAST) begin
               tmo       = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         cur_x      <= '0;
         gnt_q      <= GNT_IO;
         wait_cnt_q <= 8'd0;
         arb_err    <= 1'b0;
         io_ack     <= 1'b0;
         c64_ack    <= 1'b0;
         c64_dout   <= 8'h00;
`ifdef REU_ARB_PORT_EN
         reu_ack    <= 1'b0;
         reu_dout   <= 8'h00;
         last_reu_q <= 1'b0;
`endif
      end else begin
         io_ack  <= 1'b0;
         c64_ack <= 1'b0;
`ifdef REU_ARB_PORT_EN
         reu_ack <= 1'b0;
`endif
         if (start) begin
            cur_x <= win_x;
            gnt_q <= pick_gnt;
`ifdef REU_ARB_PORT_EN
            if (pick_gnt == GNT_C64)
               last_reu_q <= 1'b0;
            else if (pick_gnt == GNT_REU)
               last_reu_q <= 1'b1;
`endif
         end
         if (state_q == ISSUE)
            wait_cnt_q <= 8'd0;
         else if (state_q == WAIT)
            wait_cnt_q <= wait_cnt_q + 8'd1;
         if (tmo)
            arb_err <= 1'b1;
         if (done) begin
            case (gnt_q)
               GNT_IO: io_ack <= 1'b1;
               GNT_C64: begin
                  c64_ack <= 1'b1;
                  if (!cur_x.we)
                     c64_dout <= sd_dout;
               end
`ifdef REU_ARB_PORT_EN
               GNT_REU: begin
                  reu_ack <= 1'b1;
                  if (!cur_x.we)
                     reu_dout <= sd_dout;
               end
`endif
               default: ;
            endcase
         end
      end
   end

   assign sd_req  = (state_q == ISSUE);
   assign sd_we   = cur_x.we;
   assign sd_addr = cur_x.addr;
   assign sd_din  = cur_x.din;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: directed scenarios then randomized multi-requester traffic against a pending-set model.
module tb_sdram_arbiter;
   import sdram_arb_pkg::*;

   localparam int AW = 25;
`ifdef REU_ARB_PORT_EN
   localparam int NP = 3;
`else
   localparam int NP = 2;
`endif

   logic          clk_sys = 1'b0;
   logic          reset_n;
   logic          io_req, io_we, io_ack;
   logic [AW-1:0] io_addr;
   logic [7:0]    io_din;
   logic          c64_req, c64_we, c64_ack;
   logic [AW-1:0] c64_addr;
   logic [7:0]    c64_din, c64_dout;
`ifdef REU_ARB_PORT_EN
   logic          reu_req, reu_we, reu_ack;
   logic [AW-1:0] reu_addr;
   logic [7:0]    reu_din, reu_dout;
`endif
   logic          sd_req, sd_we, sd_ack;
   logic [AW-1:0] sd_addr;
   logic [7:0]    sd_din, sd_dout;
   logic          arb_err;

   int vectors = 0;
   int miscompares = 0;

   // Requester model: per-port pending transaction, driven req level and expected dout.
   logic          req_drv [3];
   bit            pend [3];
   logic          xwe [3];
   logic [AW-1:0] xaddr [3];
   logic [7:0]    xdin [3];
   logic [7:0]    exp_dout [3];
   bit            last_reu;

   sdram_arbiter #(.ADDR_W(AW), .TIMEOUT(15)) dut (
      .clk_sys  (clk_sys),
      .reset_n  (reset_n),
      .io_req   (io_req),
      .io_we    (io_we),
      .io_addr  (io_addr),
      .io_din   (io_din),
      .io_ack   (io_ack),
      .c64_req  (c64_req),
      .c64_we   (c64_we),
      .c64_addr (c64_addr),
      .c64_din  (c64_din),
      .c64_ack  (c64_ack),
      .c64_dout (c64_dout),
`ifdef REU_ARB_PORT_EN
      .reu_req  (reu_req),
      .reu_we   (reu_we),
      .reu_addr (reu_addr),
      .reu_din  (reu_din),
      .reu_ack  (reu_ack),
      .reu_dout (reu_dout),
`endif
      .sd_req   (sd_req),
      .sd_we    (sd_we),
      .sd_addr  (sd_addr),
      .sd_din   (sd_din),
      .sd_dout  (sd_dout),
      .sd_ack   (sd_ack),
      .arb_err  (arb_err)
   );

   always #5 clk_sys = ~clk_sys;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic apply();
      io_req   = req_drv[0];
      io_we    = xwe[0];
      io_addr  = xaddr[0];
      io_din   = xdin[0];
      c64_req  = req_drv[1];
      c64_we   = xwe[1];
      c64_addr = xaddr[1];
      c64_din  = xdin[1];
`ifdef REU_ARB_PORT_EN
      reu_req  = req_drv[2];
      reu_we   = xwe[2];
      reu_addr = xaddr[2];
      reu_din  = xdin[2];
`endif
   endtask

   task automatic set_x(input int p, input logic we, input logic [AW-1:0] addr, input logic [7:0] din);
      xwe[p]   = we;
      xaddr[p] = addr;
      xdin[p]  = din;
   endtask

   function automatic logic get_ack(input int p);
      case (p)
         0: return io_ack;
         1: return c64_ack;
`ifdef REU_ARB_PORT_EN
         2: return reu_ack;
`endif
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [7:0] get_dout(input int p);
      case (p)
         1: return c64_dout;
`ifdef REU_ARB_PORT_EN
         2: return reu_dout;
`endif
         default: return 8'h00;
      endcase
   endfunction

   // io first; c64/reu tie goes to whichever was not served last.
   function automatic int model_pick();
      if (pend[0]) return 0;
      if (pend[1] && pend[2]) return last_reu ? 1 : 2;
      if (pend[1]) return 1;
      return 2;
   endfunction

   initial begin
      int w;
      int lat;
      logic [7:0] d;

      for (int p = 0; p < 3; p++) begin
         req_drv[p] = 1'b0; pend[p] = 1'b0; exp_dout[p] = 8'h00;
         set_x(p, 1'b0, '0, 8'h00);
      end
      last_reu = 1'b0;
      apply();
      sd_ack = 1'b0; sd_dout = 8'h00; reset_n = 1'b0;
      tick(); tick();
      chk("rst_sd_req", sd_req, 0);
      chk("rst_sd_we", sd_we, 0);
      chk("rst_sd_addr", sd_addr, 0);
      chk("rst_sd_din", sd_din, 0);
      chk("rst_io_ack", io_ack, 0);
      chk("rst_c64_ack", c64_ack, 0);
      chk("rst_c64_dout", c64_dout, 0);
      chk("rst_arb_err", arb_err, 0);
      reset_n = 1'b1;
      tick();

      // Isolated c64 read: sd_req only in cycle 1, sd_ack in cycle 5, c64_ack in cycle 6.
      set_x(1, 1'b0, 25'h00D020, 8'h00); req_drv[1] = 1'b1; apply();
      for (int k = 1; k <= 5; k++) begin
         tick();
         chk("d1_sd_req", sd_req, (k == 1));
         chk("d1_c64_ack_early", c64_ack, 0);
         if (k == 1) chk("d1_sd_addr", sd_addr, 32'h00D020);
         if (k == 5) begin sd_ack = 1'b1; sd_dout = 8'h0E; end
      end
      tick(); sd_ack = 1'b0;
      chk("d1_c64_ack", c64_ack, 1);
      chk("d1_c64_dout", c64_dout, 8'h0E);
      exp_dout[1] = 8'h0E; req_drv[1] = 1'b0; apply();
      tick();
      chk("d1_c64_ack_once", c64_ack, 0);

      // io and c64 together: io first, c64 issued the cycle after IDLE re-entry.
      set_x(0, 1'b1, 25'h10, 8'h11); set_x(1, 1'b0, 25'h20, 8'h00);
      req_drv[0] = 1'b1; req_drv[1] = 1'b1; apply();
      tick();
      chk("d2_io_sd_req", sd_req, 1);
      chk("d2_io_sd_addr", sd_addr, 32'h10);
      chk("d2_io_sd_we", sd_we, 1);
      chk("d2_io_sd_din", sd_din, 8'h11);
      tick(); sd_ack = 1'b1; sd_dout = 8'h99;
      tick(); sd_ack = 1'b0;
      chk("d2_io_ack", io_ack, 1);
      chk("d2_c64_ack_wait", c64_ack, 0);
      chk("d2_c64_dout_keep", c64_dout, exp_dout[1]);
      req_drv[0] = 1'b0; apply();
      tick();
      chk("d2_c64_sd_req", sd_req, 1);
      chk("d2_c64_sd_addr", sd_addr, 32'h20);
      chk("d2_c64_sd_we", sd_we, 0);
      tick(); sd_ack = 1'b1; sd_dout = 8'h5A;
      tick(); sd_ack = 1'b0;
      chk("d2_c64_ack", c64_ack, 1);
      chk("d2_c64_dout", c64_dout, 8'h5A);
      exp_dout[1] = 8'h5A; req_drv[1] = 1'b0; apply();
      tick();
      chk("d2_idle", sd_req, 0);

      // Withheld sd_ack: an ack during ISSUE is ignored, 15 WAIT cycles then arb_err.
      set_x(1, 1'b0, 25'h300, 8'h00); req_drv[1] = 1'b1; apply();
      tick();
      chk("to_sd_req", sd_req, 1);
      sd_ack = 1'b1; sd_dout = 8'hEE;
      tick(); sd_ack = 1'b0; req_drv[1] = 1'b0; apply();
      for (int k = 2; k <= 16; k++) begin
         chk("to_err_early", arb_err, 0);
         chk("to_no_ack", c64_ack, 0);
         if (k < 16) tick();
      end
      tick();
      chk("to_arb_err", arb_err, 1);
      chk("to_no_ack_end", c64_ack, 0);
      chk("to_state_idle", 32'(dut.state_q), 32'(IDLE));
      chk("to_dout_keep", c64_dout, exp_dout[1]);
      set_x(1, 1'b0, 25'h301, 8'h00); req_drv[1] = 1'b1; apply();
      tick();
      chk("to_next_sd_req", sd_req, 1);
      chk("to_next_sd_addr", sd_addr, 32'h301);
      tick(); sd_ack = 1'b1; sd_dout = 8'h3C;
      tick(); sd_ack = 1'b0;
      chk("to_next_ack", c64_ack, 1);
      chk("to_next_dout", c64_dout, 8'h3C);
      chk("to_err_sticky", arb_err, 1);
      exp_dout[1] = 8'h3C; req_drv[1] = 1'b0; apply();
      tick();

      // c64 write with req and inputs dropped during WAIT.
      set_x(1, 1'b1, 25'h001000, 8'hA5); req_drv[1] = 1'b1; apply();
      tick();
      chk("wr_sd_req", sd_req, 1);
      chk("wr_sd_we", sd_we, 1);
      chk("wr_sd_din", sd_din, 8'hA5);
      chk("wr_sd_addr", sd_addr, 32'h001000);
      tick();
      set_x(1, 1'b0, '0, 8'h00); req_drv[1] = 1'b0; apply();
      for (int k = 2; k <= 3; k++) begin
         chk("wr_hold_we", sd_we, 1);
         chk("wr_hold_din", sd_din, 8'hA5);
         chk("wr_hold_addr", sd_addr, 32'h001000);
         if (k < 3) tick();
      end
      sd_ack = 1'b1; sd_dout = 8'hFF;
      tick(); sd_ack = 1'b0;
      chk("wr_c64_ack", c64_ack, 1);
      chk("wr_c64_dout_keep", c64_dout, exp_dout[1]);
      tick();
      chk("wr_ack_once", c64_ack, 0);

      // Reset during WAIT, then a stale sd_ack after release.
      set_x(1, 1'b0, 25'h2222, 8'h00); req_drv[1] = 1'b1; apply();
      tick(); tick();
      reset_n = 1'b0; #1;
      chk("rm_sd_req", sd_req, 0);
      chk("rm_sd_addr", sd_addr, 0);
      chk("rm_arb_err", arb_err, 0);
      chk("rm_c64_dout", c64_dout, 0);
      req_drv[1] = 1'b0; apply();
      for (int p = 0; p < 3; p++) exp_dout[p] = 8'h00;
      last_reu = 1'b0;
      tick();
      reset_n = 1'b1; sd_ack = 1'b1; sd_dout = 8'h77;
      tick(); sd_ack = 1'b0;
      chk("rm_stale_c64_ack", c64_ack, 0);
      chk("rm_stale_io_ack", io_ack, 0);
      chk("rm_stale_dout", c64_dout, 0);
      chk("rm_stale_sd_req", sd_req, 0);
      chk("rm_state_idle", 32'(dut.state_q), 32'(IDLE));
      tick();
      chk("rm_idle_sd_req", sd_req, 0);

`ifdef REU_ARB_PORT_EN
      // c64 and reu requesting continuously: reu wins the first tie after reset, then alternate.
      set_x(1, 1'b0, 25'h100, 8'h00); set_x(2, 1'b0, 25'h200, 8'h00);
      req_drv[1] = 1'b1; req_drv[2] = 1'b1; apply();
      for (int t = 0; t < 4; t++) begin
         w = (t % 2 == 0) ? 2 : 1;
         tick();
         chk("rr_sd_addr", sd_addr, 32'(xaddr[w]));
         tick(); d = 8'($urandom); sd_ack = 1'b1; sd_dout = d;
         tick(); sd_ack = 1'b0;
         chk("rr_ack_win", get_ack(w), 1);
         chk("rr_ack_lose", get_ack(3 - w), 0);
         exp_dout[w] = d;
         chk("rr_dout", get_dout(w), d);
         if (t == 3) begin req_drv[1] = 1'b0; req_drv[2] = 1'b0; apply(); end
      end
      last_reu = 1'b0;
      tick();
      chk("rr_idle", sd_req, 0);
`endif

      // Randomized rounds: random subsets of requesters, random sd latency, random mid-WAIT req drop.
      for (int r = 0; r < 60; r++) begin
         for (int p = 0; p < NP; p++) begin
            if ($urandom_range(0, 1) == 1) begin
               pend[p] = 1'b1; req_drv[p] = 1'b1;
               set_x(p, 1'($urandom), AW'($urandom), 8'($urandom));
            end
         end
         if (!pend[0] && !pend[1] && !pend[2]) begin
            pend[1] = 1'b1; req_drv[1] = 1'b1;
            set_x(1, 1'($urandom), AW'($urandom), 8'($urandom));
         end
         apply();
         while (pend[0] || pend[1] || pend[2]) begin
            w = model_pick();
            tick();
            chk("rnd_sd_req", sd_req, 1);
            chk("rnd_sd_addr", sd_addr, 32'(xaddr[w]));
            chk("rnd_sd_we", sd_we, xwe[w]);
            chk("rnd_sd_din", sd_din, xdin[w]);
            lat = $urandom_range(1, 6);
            tick();
            if ($urandom_range(0, 3) == 0) begin req_drv[w] = 1'b0; apply(); end
            for (int k = 1; k < lat; k++) tick();
            chk("rnd_wait_sd_req", sd_req, 0);
            d = 8'($urandom); sd_ack = 1'b1; sd_dout = d;
            tick(); sd_ack = 1'b0;
            for (int q = 0; q < NP; q++)
               chk("rnd_ack", get_ack(q), (q == w));
            if (w != 0) begin
               if (!xwe[w]) exp_dout[w] = d;
               chk("rnd_dout", get_dout(w), exp_dout[w]);
            end
            if (w == 1) last_reu = 1'b0;
            if (w == 2) last_reu = 1'b1;
            pend[w] = 1'b0; req_drv[w] = 1'b0; apply();
         end
         tick();
         chk("rnd_idle", sd_req, 0);
      end
      chk("end_arb_err", arb_err, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
